// File: rtl/sram_ctrl_pkg.sv
// Shared geometry and controller state type for the 128x64 SRAM front-end.
package sram_ctrl_pkg;

    localparam int SRAM_DEPTH = 128;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 64;
    localparam int BE_W       = 8;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small fall-through FIFO holding read responses; head is visible while count != 0.
module sram_rsp_fifo #(
    parameter  int DEPTH = 3,
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

    a_no_overflow: assert property (@(posedge clk) disable iff (srst)
        !(push && !do_pop && (count_reg == CNT_W'(DEPTH))));

endmodule

// File: rtl/sram_128x64_ctrl.sv
// Valid/ready request front-end for the 128x64 SRAM wrapper with credit-guarded response FIFO.
// Optional power-up zero fill of the whole array is enabled by defining SRAM_CTRL_INIT_EN.
module sram_128x64_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int RSP_DEPTH = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [BE_W-1:0]   i_req_be,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_init_done,
    output logic              o_sram_cen,
    output logic              o_sram_wen,
    output logic [DATA_W-1:0] o_sram_bit_mask,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata
);

    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int CRED_W = $clog2(RSP_DEPTH + 2);

`ifdef SRAM_CTRL_INIT_EN
    localparam ctrl_state_e RESET_STATE = S_INIT;
`else
    localparam ctrl_state_e RESET_STATE = S_RUN;
`endif

    ctrl_state_e       state_reg;
    ctrl_state_e       state_next;
    logic              rd_inflight_reg;
    logic [CNT_W-1:0]  fifo_count;
    logic [CRED_W-1:0] credits;
    logic [DATA_W-1:0] be_mask;
    logic              req_fire;

`ifdef SRAM_CTRL_INIT_EN
    logic [ADDR_W-1:0] init_cnt_reg;
`endif

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be_mask
        assign be_mask[8*gi +: 8] = {8{i_req_be[gi]}};
    end

    // A read in flight already owns a FIFO slot, so it counts as a credit.
    assign credits     = CRED_W'(fifo_count) + CRED_W'(rd_inflight_reg);
    assign o_req_ready = (state_reg == S_RUN) && !i_rst && (credits < CRED_W'(RSP_DEPTH));
    assign req_fire    = i_req_valid && o_req_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= RESET_STATE;
            rd_inflight_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rd_inflight_reg <= req_fire && !i_req_we;
        end
    end

`ifdef SRAM_CTRL_INIT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            init_cnt_reg <= '0;
        end else if (state_reg == S_INIT) begin
            init_cnt_reg <= init_cnt_reg + 1'b1;
        end
    end
`endif

    always_comb begin
        state_next      = state_reg;
        o_sram_cen      = 1'b0;
        o_sram_wen      = 1'b0;
        o_sram_bit_mask = '0;
        o_sram_addr     = i_req_addr;
        o_sram_wdata    = i_req_wdata;
        case (state_reg)
            S_INIT: begin
`ifdef SRAM_CTRL_INIT_EN
                o_sram_cen      = 1'b1;
                o_sram_wen      = 1'b1;
                o_sram_bit_mask = '1;
                o_sram_addr     = init_cnt_reg;
                o_sram_wdata    = '0;
                if (init_cnt_reg == ADDR_W'(SRAM_DEPTH - 1)) begin
                    state_next = S_RUN;
                end
`else
                state_next = S_RUN;
`endif
            end
            S_RUN: begin
                if (req_fire) begin
                    o_sram_cen      = 1'b1;
                    o_sram_wen      = i_req_we;
                    o_sram_bit_mask = be_mask;
                end
            end
            default: state_next = RESET_STATE;
        endcase
        // Keep the macro idle while reset is held, including during init.
        if (i_rst) begin
            o_sram_cen      = 1'b0;
            o_sram_wen      = 1'b0;
            o_sram_bit_mask = '0;
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk   (i_clk),
        .srst  (i_rst),
        .push  (rd_inflight_reg),
        .wdata (i_sram_rdata),
        .pop   (o_rsp_valid && i_rsp_ready),
        .count (fifo_count),
        .head  (o_rsp_rdata)
    );

    assign o_rsp_valid = (fifo_count != '0);
    assign o_init_done = (state_reg == S_RUN);

endmodule

// File: tb/tb_sram_128x64_ctrl.sv
// Scoreboard bench for sram_128x64_ctrl with a behavioural SRAM and byte-level reference memory.
module tb_sram_128x64_ctrl;

    localparam int RSP_DEPTH = 3;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [6:0]  i_req_addr;
    logic [63:0] i_req_wdata;
    logic [7:0]  i_req_be;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [63:0] o_rsp_rdata;
    logic        o_init_done;
    logic        o_sram_cen;
    logic        o_sram_wen;
    logic [63:0] o_sram_bit_mask;
    logic [6:0]  o_sram_addr;
    logic [63:0] o_sram_wdata;
    logic [63:0] i_sram_rdata;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          exact_lat = 1'b0;
    bit          rand_ready = 1'b0;
    logic [63:0] sram_mem [128];
    logic [63:0] ref_mem [128];

    always #5 clk = ~clk;

    sram_128x64_ctrl #(.RSP_DEPTH(RSP_DEPTH)) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_we        (i_req_we),
        .i_req_addr      (i_req_addr),
        .i_req_wdata     (i_req_wdata),
        .i_req_be        (i_req_be),
        .o_rsp_valid     (o_rsp_valid),
        .i_rsp_ready     (i_rsp_ready),
        .o_rsp_rdata     (o_rsp_rdata),
        .o_init_done     (o_init_done),
        .o_sram_cen      (o_sram_cen),
        .o_sram_wen      (o_sram_wen),
        .o_sram_bit_mask (o_sram_bit_mask),
        .o_sram_addr     (o_sram_addr),
        .o_sram_wdata    (o_sram_wdata),
        .i_sram_rdata    (i_sram_rdata)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port macro: masked write, registered read.
    always @(posedge clk) begin
        if (o_sram_cen) begin
            if (o_sram_wen) begin
                sram_mem[o_sram_addr] <= (sram_mem[o_sram_addr] & ~o_sram_bit_mask) |
                                         (o_sram_wdata & o_sram_bit_mask);
            end else begin
                i_sram_rdata <= sram_mem[o_sram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] expand_be(input logic [7:0] be);
        logic [63:0] m = '0;
        for (int k = 0; k < 8; k++) if (be[k]) m[8*k +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic ref_write(input logic [6:0] a, input logic [63:0] d, input logic [7:0] be);
        for (int k = 0; k < 8; k++) if (be[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic issue(input bit we, input logic [6:0] a, input logic [63:0] d,
                         input logic [7:0] be, output int waited);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_wdata = d;
        i_req_be    = be;
        waited      = 0;
        @(negedge clk);
        while (!o_req_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!o_req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got ready=0 for %0d cycles, expected ready=1", waited);
        end else begin
            chk("sram_ctl", 64'({o_sram_cen, o_sram_wen, o_sram_addr}), 64'({1'b1, we, a}));
            chk("sram_mask", o_sram_bit_mask, expand_be(be));
            if (we) chk("sram_wdata", o_sram_wdata, d);
            if (we) ref_write(a, d, be);
            else    exp_q.push_back('{ref_mem[a], cyc});
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    // Read with an empty FIFO and rsp_ready=1: data must appear exactly two cycles later.
    task automatic read_exact(input string name, input logic [6:0] a, input logic [63:0] req);
        int w;
        issue(1'b0, a, 64'h0, 8'hFF, w);
        @(negedge clk);
        chk({name, "_n1_valid"}, 64'(o_rsp_valid), 64'd0);
        @(negedge clk);
        chk({name, "_n2_valid"}, 64'(o_rsp_valid), 64'd1);
        chk(name, o_rsp_rdata, req);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!i_rst && o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got rdata %h, expected no response", o_rsp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_data", o_rsp_rdata, mon_e.data);
                if (exact_lat) chk("rsp_latency", 64'(cyc), 64'(mon_e.cyc + 2));
                else           chk("rsp_min_latency", 64'(cyc >= mon_e.cyc + 2), 64'd1);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) i_rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int acc;
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_req_be    = '0;
        i_rsp_ready = 1'b1;
        for (int i = 0; i < 128; i++) ref_mem[i] = 64'h0;

        wait_cycles(2);
        @(negedge clk);
        chk("reset_outputs", 64'({o_req_ready, o_sram_cen, o_sram_wen, o_rsp_valid}), 64'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;

`ifdef SRAM_CTRL_INIT_EN
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            chk("init_flags", 64'({o_init_done, o_req_ready, o_sram_cen, o_sram_wen}), 64'b0011);
            chk("init_addr", 64'(o_sram_addr), 64'(i));
            chk("init_mask_data", {o_sram_bit_mask ^ 64'hFFFF_FFFF_FFFF_FFFF} | o_sram_wdata, 64'h0);
        end
        @(negedge clk);
        chk("init_done_rise", 64'({o_init_done, o_req_ready}), 64'b11);
        @(posedge clk);
        #1;
        exact_lat = 1'b1;
        read_exact("init_read127", 7'd127, 64'h0);
`else
        @(negedge clk);
        chk("post_reset_run", 64'({o_init_done, o_req_ready, o_rsp_valid}), 64'b110);
        @(posedge clk);
        #1;
`endif

        exact_lat = 1'b1;
        for (int a = 0; a < 128; a++) issue(1'b1, 7'(a), {$urandom, $urandom}, 8'hFF, w);

        issue(1'b1, 7'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF, w);
        read_exact("rd_addr5", 7'd5, 64'hDEADBEEF_CAFEF00D);

        issue(1'b1, 7'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, w);
        issue(1'b1, 7'd9, 64'h0, 8'h0F, w);
        read_exact("rd_partial", 7'd9, 64'hFFFFFFFF_00000000);

        issue(1'b1, 7'd20, 64'h0123_4567_89AB_CDEF, 8'h00, w);
        read_exact("rd_be_zero", 7'd20, ref_mem[20]);

        for (int a = 0; a < 16; a++) begin
            issue(1'b0, 7'(a), 64'h0, 8'hFF, w);
            chk("sustain_ready_wait", 64'(w), 64'd0);
        end
        wait_cycles(4);
        chk("sustain_drain", 64'(exp_q.size()), 64'd0);

        exact_lat   = 1'b0;
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_be    = 8'hFF;
        acc         = 0;
        for (int i = 0; i < 12; i++) begin
            i_req_addr = 7'($urandom);
            @(negedge clk);
            if (o_req_ready) begin
                acc++;
                exp_q.push_back('{ref_mem[i_req_addr], cyc});
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 64'(acc), 64'(RSP_DEPTH));
        @(negedge clk);
        chk("bp_stall", 64'({o_req_ready, o_rsp_valid}), 64'b01);
        @(posedge clk);
        #1;
        i_rsp_ready = 1'b1;
        acc         = 0;
        for (int i = 0; i < 12; i++) begin
            i_req_addr = 7'($urandom);
            @(negedge clk);
            if (o_req_ready) begin
                acc++;
                exp_q.push_back('{ref_mem[i_req_addr], cyc});
            end
            @(posedge clk);
            #1;
        end
        i_req_valid = 1'b0;
        chk("bp_resume", 64'(acc >= 8), 64'd1);
        wait_cycles(6);
        chk("bp_drain", 64'(exp_q.size()), 64'd0);

        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom), 7'($urandom), {$urandom, $urandom}, 8'($urandom), w);
            if ($urandom_range(0, 1) != 0) wait_cycles(1);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        i_rsp_ready = 1'b1;
        wait_cycles(8);
        chk("random_drain", 64'(exp_q.size()), 64'd0);

        exact_lat = 1'b1;
        issue(1'b0, 7'd5, 64'h0, 8'hFF, w);
        i_rst       = 1'b1;
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 7'd3;
        @(negedge clk);
        chk("rst_forced", 64'({o_req_ready, o_sram_cen}), 64'd0);
        @(posedge clk);
        #1;
        i_rst       = 1'b0;
        i_req_valid = 1'b0;
        exp_q.delete();
`ifdef SRAM_CTRL_INIT_EN
        for (int i = 0; i < 128; i++) ref_mem[i] = 64'h0;
        w = 0;
        @(negedge clk);
        while (!o_init_done && w < 300) begin
            w++;
            @(negedge clk);
        end
        chk("reinit_cycles", 64'(w), 64'd128);
`else
        @(negedge clk);
`endif
        for (int i = 0; i < 3; i++) begin
            chk("rst_no_rsp", 64'({o_rsp_valid, o_req_ready}), 64'b01);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        read_exact("rd_after_rst", 7'd5, ref_mem[5]);
        wait_cycles(4);
        chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
